// File: rtl/cpumc_arb_if.sv
// +----------------------------------------------------------------------------+
// | cpumc_arb_if : CPU / sprite DMA / DMC sample bus bundle for cpumc_arb      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cpumc_arb_if;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic        cpu_rdy_out;
  logic        spr_req_in;
  logic [15:0] spr_a_in;
  logic [7:0]  spr_d_in;
  logic        spr_r_nw_in;
  logic        dmc_req_in;
  logic [15:0] dmc_a_in;
  logic        dmc_ack_out;
  logic [7:0]  dmc_d_out;
  logic [15:0] cpumc_a_out;
  logic [7:0]  cpumc_d_out;
  logic        cpumc_r_nw_out;
  logic [7:0]  cpumc_dout_in;
  logic [1:0]  grant_out;

  modport slave (
    input  cpu_a_in, cpu_d_in, cpu_r_nw_in,
    input  spr_req_in, spr_a_in, spr_d_in, spr_r_nw_in,
    input  dmc_req_in, dmc_a_in, cpumc_dout_in,
    output cpu_rdy_out, dmc_ack_out, dmc_d_out,
    output cpumc_a_out, cpumc_d_out, cpumc_r_nw_out, grant_out
  );

  modport master (
    output cpu_a_in, cpu_d_in, cpu_r_nw_in,
    output spr_req_in, spr_a_in, spr_d_in, spr_r_nw_in,
    output dmc_req_in, dmc_a_in, cpumc_dout_in,
    input  cpu_rdy_out, dmc_ack_out, dmc_d_out,
    input  cpumc_a_out, cpumc_d_out, cpumc_r_nw_out, grant_out
  );
endinterface

`default_nettype wire

// File: rtl/cpumc_arb.sv
// +----------------------------------------------------------------------------+
// | cpumc_arb : arbitrates the CPU memory bus between CPU, sprite DMA and DMC  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpumc_arb #(
  parameter int DMC_STALL = 3
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  cpumc_arb_if.slave  bus_io
);

  localparam int            CW         = (DMC_STALL < 2) ? 1 : $clog2(DMC_STALL + 1);
  localparam logic [CW-1:0] STALL_LOAD = CW'((DMC_STALL > 0) ? (DMC_STALL - 1) : 0);

  localparam logic [2:0] S_CPU       = 3'd0;
  localparam logic [2:0] S_HALT      = 3'd1;
  localparam logic [2:0] S_SPR       = 3'd2;
  localparam logic [2:0] S_DMC_STALL = 3'd3;
  localparam logic [2:0] S_DMC_RD    = 3'd4;
  localparam logic [2:0] S_DMC_DONE  = 3'd5;

  localparam logic [2:0] DMC_ENTRY   = (DMC_STALL == 0) ? S_DMC_RD : S_DMC_STALL;

  logic [2:0]    state_q, state_d;
  logic          pend_q,  pend_d;
  logic [15:0]   addr_q,  addr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [7:0]    dmcd_q,  dmcd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CPU: begin
        if (pend_q || bus_io.spr_req_in) state_d = S_HALT;
      end
      S_HALT: begin
        // Hold off the switch until a read cycle so CPU writes complete.
        if (bus_io.cpu_r_nw_in) begin
          if (pend_q) begin
            state_d = DMC_ENTRY;
            cnt_d   = STALL_LOAD;
          end else if (bus_io.spr_req_in) begin
            state_d = S_SPR;
          end else begin
            state_d = S_CPU;
          end
        end
      end
      S_SPR: begin
        if (!bus_io.spr_req_in) begin
          if (pend_q) begin
            state_d = DMC_ENTRY;
            cnt_d   = STALL_LOAD;
          end else begin
            state_d = S_CPU;
          end
        end
      end
      S_DMC_STALL: begin
        if (cnt_q == '0) state_d = S_DMC_RD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DMC_RD:   state_d = S_DMC_DONE;
      S_DMC_DONE: state_d = bus_io.spr_req_in ? S_SPR : S_CPU;
      default:    state_d = S_CPU;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    dmcd_d = dmcd_q;
    if (state_q == S_DMC_DONE) begin
      // Completion clears the slot; a request in the same cycle refills it.
      pend_d = bus_io.dmc_req_in;
      dmcd_d = bus_io.cpumc_dout_in;
      if (bus_io.dmc_req_in) addr_d = bus_io.dmc_a_in;
    end else if (bus_io.dmc_req_in && !pend_q) begin
      pend_d = 1'b1;
      addr_d = bus_io.dmc_a_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_CPU;
      pend_q  <= 1'b0;
      addr_q  <= 16'h0000;
      cnt_q   <= '0;
      dmcd_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dmcd_q  <= dmcd_d;
    end
  end

  always_comb begin
    bus_io.cpumc_a_out    = 16'h0000;
    bus_io.cpumc_d_out    = 8'h00;
    bus_io.cpumc_r_nw_out = 1'b1;
    bus_io.grant_out      = 2'd3;
    case (state_q)
      S_CPU, S_HALT: begin
        bus_io.cpumc_a_out    = bus_io.cpu_a_in;
        bus_io.cpumc_d_out    = bus_io.cpu_d_in;
        bus_io.cpumc_r_nw_out = bus_io.cpu_r_nw_in;
        bus_io.grant_out      = 2'd0;
      end
      S_SPR: begin
        bus_io.cpumc_a_out    = bus_io.spr_a_in;
        bus_io.cpumc_d_out    = bus_io.spr_d_in;
        bus_io.cpumc_r_nw_out = bus_io.spr_r_nw_in;
        bus_io.grant_out      = 2'd1;
      end
      S_DMC_RD, S_DMC_DONE: begin
        bus_io.cpumc_a_out    = addr_q;
        bus_io.grant_out      = 2'd2;
      end
      default: ;
    endcase
  end

  assign bus_io.cpu_rdy_out = (state_q == S_CPU);
  assign bus_io.dmc_ack_out = (state_q == S_DMC_DONE);
  // The fetched byte arrives during the ack cycle, so pass it through then.
  assign bus_io.dmc_d_out   = (state_q == S_DMC_DONE) ? bus_io.cpumc_dout_in : dmcd_q;

endmodule

`default_nettype wire

// File: tb/tb_cpumc_arb.sv
// +----------------------------------------------------------------------------+
// | tb_cpumc_arb : directed self-checking bench for cpumc_arb                  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpumc_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpumc_arb_if bus ();

  cpumc_arb #(.DMC_STALL(3)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus_io   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        rst_n;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        crnw;
    logic        dreq;
    logic [15:0] da;
    logic [7:0]  mem;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl [13];

  // Packed view: {pad, rdy, grant, a, d, r_nw, ack, dmc_d}
  function automatic logic [39:0] ex(input logic rdy, input logic [1:0] g,
                                     input logic [15:0] a, input logic [7:0] d,
                                     input logic rnw, input logic ack,
                                     input logic [7:0] dd);
    return {3'b000, rdy, g, a, d, rnw, ack, dd};
  endfunction

  function automatic logic [39:0] obs();
    return {3'b000, bus.cpu_rdy_out, bus.grant_out, bus.cpumc_a_out, bus.cpumc_d_out,
            bus.cpumc_r_nw_out, bus.dmc_ack_out, bus.dmc_d_out};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/gnt/a/d/rnw/ack/dd=%h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic [39:0] exp);
    #2;
    chk(nm, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic setcpu(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    bus.cpu_a_in    = a;
    bus.cpu_d_in    = d;
    bus.cpu_r_nw_in = rnw;
  endtask

  task automatic setspr(input logic req, input logic [15:0] a, input logic [7:0] d, input logic rnw);
    bus.spr_req_in  = req;
    bus.spr_a_in    = a;
    bus.spr_d_in    = d;
    bus.spr_r_nw_in = rnw;
  endtask

  initial begin
    setcpu(16'h0000, 8'h00, 1'b1);
    setspr(1'b0, 16'h0000, 8'h00, 1'b1);
    bus.dmc_req_in    = 1'b0;
    bus.dmc_a_in      = 16'h0000;
    bus.cpumc_dout_in = 8'h00;

    // Reset, idle mirroring, then a DMC fetch from S_CPU (ack at cycle 7).
    tbl[0]  = '{1'b0, 16'h1234, 8'hAA, 1'b1, 1'b0, 16'h0000, 8'h00, ex(1, 0, 16'h1234, 8'hAA, 1, 0, 8'h00)};
    tbl[1]  = '{1'b1, 16'h2000, 8'h11, 1'b0, 1'b0, 16'h0000, 8'h00, ex(1, 0, 16'h2000, 8'h11, 0, 0, 8'h00)};
    tbl[2]  = '{1'b1, 16'h2001, 8'h22, 1'b0, 1'b0, 16'h0000, 8'h00, ex(1, 0, 16'h2001, 8'h22, 0, 0, 8'h00)};
    tbl[3]  = '{1'b1, 16'h8000, 8'h33, 1'b1, 1'b0, 16'h0000, 8'h00, ex(1, 0, 16'h8000, 8'h33, 1, 0, 8'h00)};
    tbl[4]  = '{1'b1, 16'h8001, 8'h00, 1'b1, 1'b1, 16'hC123, 8'h00, ex(1, 0, 16'h8001, 8'h00, 1, 0, 8'h00)};
    tbl[5]  = '{1'b1, 16'h8002, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, ex(1, 0, 16'h8002, 8'h00, 1, 0, 8'h00)};
    tbl[6]  = '{1'b1, 16'h8003, 8'h44, 1'b1, 1'b0, 16'h0000, 8'h00, ex(0, 0, 16'h8003, 8'h44, 1, 0, 8'h00)};
    tbl[7]  = '{1'b1, 16'h8004, 8'h55, 1'b1, 1'b0, 16'h0000, 8'h00, ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h00)};
    tbl[8]  = '{1'b1, 16'h8004, 8'h55, 1'b1, 1'b0, 16'h0000, 8'h00, ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h00)};
    tbl[9]  = '{1'b1, 16'h8004, 8'h55, 1'b1, 1'b0, 16'h0000, 8'h00, ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h00)};
    tbl[10] = '{1'b1, 16'h8004, 8'h55, 1'b1, 1'b0, 16'h0000, 8'h00, ex(0, 2, 16'hC123, 8'h00, 1, 0, 8'h00)};
    tbl[11] = '{1'b1, 16'h8004, 8'h55, 1'b1, 1'b0, 16'h0000, 8'h5A, ex(0, 2, 16'hC123, 8'h00, 1, 1, 8'h5A)};
    tbl[12] = '{1'b1, 16'h9000, 8'h66, 1'b0, 1'b0, 16'h0000, 8'h77, ex(1, 0, 16'h9000, 8'h66, 0, 0, 8'h5A)};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      rst_n             = tbl[i].rst_n;
      setcpu(tbl[i].ca, tbl[i].cd, tbl[i].crnw);
      bus.dmc_req_in    = tbl[i].dreq;
      bus.dmc_a_in      = tbl[i].da;
      bus.cpumc_dout_in = tbl[i].mem;
      step($sformatf("vec%0d", i), tbl[i].exp);
    end
    bus.cpumc_dout_in = 8'h00;

    // Sprite request during a CPU write run: halt until the first read.
    setcpu(16'hA000, 8'h01, 1'b0);
    setspr(1'b1, 16'h4000, 8'hE0, 1'b1);
    step("sprA_cpu",     ex(1, 0, 16'hA000, 8'h01, 0, 0, 8'h5A));
    setcpu(16'hA001, 8'h02, 1'b0);
    step("sprA_halt_w1", ex(0, 0, 16'hA001, 8'h02, 0, 0, 8'h5A));
    setcpu(16'hA002, 8'h03, 1'b0);
    step("sprA_halt_w2", ex(0, 0, 16'hA002, 8'h03, 0, 0, 8'h5A));
    setcpu(16'hA003, 8'h04, 1'b1);
    step("sprA_halt_rd", ex(0, 0, 16'hA003, 8'h04, 1, 0, 8'h5A));
    for (int i = 0; i < 3; i++) begin
      setspr(1'b1, 16'h4000 + 16'(i), 8'hE0 + 8'(i), (i % 2 == 0));
      step("sprA_xfer", ex(0, 1, 16'h4000 + 16'(i), 8'hE0 + 8'(i), (i % 2 == 0), 0, 8'h5A));
    end
    setspr(1'b0, 16'h4003, 8'hE3, 1'b0);
    step("sprA_last",    ex(0, 1, 16'h4003, 8'hE3, 0, 0, 8'h5A));
    setcpu(16'hA004, 8'h05, 1'b1);
    setspr(1'b0, 16'h0000, 8'h00, 1'b1);
    step("sprA_back",    ex(1, 0, 16'hA004, 8'h05, 1, 0, 8'h5A));

    // DMC request during sprite: no preemption, second pulse dropped.
    setcpu(16'hA100, 8'h00, 1'b1);
    setspr(1'b1, 16'h5000, 8'hC0, 1'b1);
    step("sprB_cpu",  ex(1, 0, 16'hA100, 8'h00, 1, 0, 8'h5A));
    step("sprB_halt", ex(0, 0, 16'hA100, 8'h00, 1, 0, 8'h5A));
    bus.dmc_req_in = 1'b1; bus.dmc_a_in = 16'hBEEF;
    step("sprB_s0",   ex(0, 1, 16'h5000, 8'hC0, 1, 0, 8'h5A));
    bus.dmc_a_in = 16'h1111;
    step("sprB_s1",   ex(0, 1, 16'h5000, 8'hC0, 1, 0, 8'h5A));
    bus.dmc_req_in = 1'b0; bus.dmc_a_in = 16'h0000;
    step("sprB_s2",   ex(0, 1, 16'h5000, 8'hC0, 1, 0, 8'h5A));
    bus.spr_req_in = 1'b0;
    step("sprB_s3",   ex(0, 1, 16'h5000, 8'hC0, 1, 0, 8'h5A));
    setspr(1'b0, 16'h0000, 8'h00, 1'b1);
    repeat (3) step("sprB_stall", ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h5A));
    step("sprB_rd",   ex(0, 2, 16'hBEEF, 8'h00, 1, 0, 8'h5A));
    bus.cpumc_dout_in = 8'h3C;
    step("sprB_done", ex(0, 2, 16'hBEEF, 8'h00, 1, 1, 8'h3C));
    bus.cpumc_dout_in = 8'h00;
    repeat (6) step("sprB_after", ex(1, 0, 16'hA100, 8'h00, 1, 0, 8'h3C));

    // New request in the ack cycle wins over the clear.
    setcpu(16'hA200, 8'h00, 1'b1);
    bus.dmc_req_in = 1'b1; bus.dmc_a_in = 16'h0100;
    step("reqC_cpu0", ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h3C));
    bus.dmc_req_in = 1'b0;
    step("reqC_cpu1", ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h3C));
    step("reqC_halt", ex(0, 0, 16'hA200, 8'h00, 1, 0, 8'h3C));
    repeat (3) step("reqC_stall", ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h3C));
    step("reqC_rd",   ex(0, 2, 16'h0100, 8'h00, 1, 0, 8'h3C));
    bus.cpumc_dout_in = 8'h99;
    bus.dmc_req_in = 1'b1; bus.dmc_a_in = 16'h0200;
    step("reqC_done", ex(0, 2, 16'h0100, 8'h00, 1, 1, 8'h99));
    bus.cpumc_dout_in = 8'h00;
    bus.dmc_req_in = 1'b0; bus.dmc_a_in = 16'h0000;
    step("reqC_cpu2",  ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h99));
    step("reqC_halt2", ex(0, 0, 16'hA200, 8'h00, 1, 0, 8'h99));
    repeat (3) step("reqC_stall2", ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h99));
    step("reqC_rd2",   ex(0, 2, 16'h0200, 8'h00, 1, 0, 8'h99));
    bus.cpumc_dout_in = 8'h42;
    step("reqC_done2", ex(0, 2, 16'h0200, 8'h00, 1, 1, 8'h42));
    bus.cpumc_dout_in = 8'h00;
    step("reqC_back",  ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h42));

    // Asynchronous reset in the middle of the stall window.
    bus.dmc_req_in = 1'b1; bus.dmc_a_in = 16'h0300;
    step("rstD_cpu0",  ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h42));
    bus.dmc_req_in = 1'b0; bus.dmc_a_in = 16'h0000;
    step("rstD_cpu1",  ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h42));
    step("rstD_halt",  ex(0, 0, 16'hA200, 8'h00, 1, 0, 8'h42));
    step("rstD_stall", ex(0, 3, 16'h0000, 8'h00, 1, 0, 8'h42));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstD_async", obs(), ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h00));
    @(posedge clk);
    #1;
    step("rstD_held", ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h00));
    rst_n = 1'b1;
    repeat (8) step("rstD_after", ex(1, 0, 16'hA200, 8'h00, 1, 0, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpumc_arb.md
CPUMC_ARB -- requirements
Module: cpumc_arb

Interface
REQ-001 Parameter: DMC_STALL, default 3, idle bus cycles inserted before each DMC sample read.
REQ-002 clk_in  input  1  100MHz system clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  reset; asynchronous, active-low.
REQ-004 cpu_a_in  input  16  CPU address bus.
REQ-005 cpu_d_in  input  8  CPU write data.
REQ-006 cpu_r_nw_in  input  1  CPU read(1)/write(0).
REQ-007 cpu_rdy_out  output  1  CPU ready; low halts the CPU.
REQ-008 spr_req_in  input  1  sprite DMA active; held high for the whole 256-byte transfer.
REQ-009 spr_a_in, spr_d_in, spr_r_nw_in  input  16/8/1  sprite DMA bus request.
REQ-010 dmc_req_in  input  1  one-cycle pulse requesting one DMC sample byte.
REQ-011 dmc_a_in  input  16  DMC sample address, valid with dmc_req_in.
REQ-012 dmc_ack_out  output  1  one-cycle pulse; dmc_d_out valid.
REQ-013 dmc_d_out  output  8  fetched DMC sample byte.
REQ-014 cpumc_a_out, cpumc_d_out, cpumc_r_nw_out  output  16/8/1  arbitrated memory bus.
REQ-015 cpumc_dout_in  input  8  memory read data; valid the cycle after the address is presented.
REQ-016 grant_out  output  2  bus owner: 0 CPU, 1 sprite, 2 DMC, 3 idle.

Function
REQ-017 The FSM SHALL have the states S_CPU, S_HALT, S_SPR, S_DMC_STALL, S_DMC_RD and S_DMC_DONE.
REQ-018 The block SHALL hold a single-entry DMC pending flag plus a 16-bit latched address; a dmc_req_in pulse while not pending sets the flag and latches dmc_a_in.
REQ-019 A dmc_req_in pulse while pending and not in S_DMC_DONE SHALL be dropped with no state change.
REQ-020 In S_DMC_DONE the pending flag SHALL clear; a simultaneous dmc_req_in SHALL re-set it with the new address (set wins).
REQ-021 cpu_rdy_out SHALL be 1 only in S_CPU, decoded from the registered state.
REQ-022 S_CPU: bus = CPU, grant 0; if pending or spr_req_in, next state is S_HALT.
REQ-023 S_HALT: bus = CPU, grant 0 (CPU may finish writes); on a cycle with cpu_r_nw_in=1, next state SHALL be S_DMC_STALL if pending, else S_SPR if spr_req_in, else S_CPU.
REQ-024 S_SPR: bus = spr_* inputs, grant 1; when spr_req_in=0, next state SHALL be S_DMC_STALL if pending, else S_CPU.
REQ-025 A DMC request SHALL NOT preempt S_SPR; it is serviced after the sprite transfer ends (DMC over sprite only at the S_HALT decision point).
REQ-026 S_DMC_STALL: bus idle (a=0x0000, d=0x00, r_nw=1), grant 3, for exactly DMC_STALL cycles via a down-counter, then S_DMC_RD.
REQ-027 S_DMC_RD: a = latched DMC address, r_nw=1, grant 2, one cycle, then S_DMC_DONE.
REQ-028 S_DMC_DONE: a = latched address, grant 2; capture cpumc_dout_in into dmc_d_out and pulse dmc_ack_out for that cycle; next state SHALL be S_SPR if spr_req_in, else S_CPU.
REQ-029 Latency from dmc_req_in in S_CPU with CPU reading SHALL be DMC_STALL+4 cycles to dmc_ack_out.
REQ-030 Bus outputs SHALL be combinational muxes of the registered state; in grant 0 cpumc_* equals cpu_* exactly.

Reset
REQ-031 While rst_n_in=0: state S_CPU, pending 0, latched address 0x0000, stall counter 0, dmc_d_out 0x00, dmc_ack_out 0, cpu_rdy_out 1, grant_out 0.
REQ-032 A reset mid-transfer SHALL abort the transfer, drop any pending request, and not generate dmc_ack_out.

Verification
REQ-033 Idle: CPU reads/writes with no requests -> cpu_rdy_out stays 1, cpumc_* mirrors cpu_*, grant 0.
REQ-034 spr_req_in rises during a CPU write run -> S_HALT until the first cpu_r_nw_in=1 cycle, then grant 1 for the full spr_req_in window, then grant 0 and cpu_rdy_out 1.
REQ-035 dmc_req_in with a=0xC123 and memory byte 0x5A -> 3 idle cycles, address 0xC123, dmc_ack_out pulse with dmc_d_out=0x5A at cycle 7.
REQ-036 dmc_req_in during S_SPR -> sprite completes uninterrupted, then the DMC fetch runs, then S_CPU; a second pulse while pending is dropped (one ack only).
REQ-037 rst_n_in asserted in S_DMC_STALL -> all outputs at reset values immediately (asynchronously), no ack, S_CPU after release.
